// File: rtl/proc_control_unit.sv
// Control FSM for the 9-bit bus-based processor: IR capture, decode and T0..T3 sequencing.
// Optional build macro MVNZ_EN enables opcode 100 (mvnz, conditional move on G != 0).
module proc_control_unit #(
    parameter int unsigned N = 9
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    input  logic         G_nz,
    output logic         IRin,
    output logic [7:0]   Rin,
    output logic [7:0]   Rout,
    output logic         Ain,
    output logic         Gin,
    output logic         Gout,
    output logic         DINout,
    output logic         AddSub,
    output logic         Done,
    output logic [1:0]   Tstep
);

    localparam int unsigned IR_W = 9;
    localparam logic [2:0]  OP_MV   = 3'b000;
    localparam logic [2:0]  OP_MVI  = 3'b001;
    localparam logic [2:0]  OP_ADD  = 3'b010;
    localparam logic [2:0]  OP_SUB  = 3'b011;
`ifdef MVNZ_EN
    localparam logic [2:0]  OP_MVNZ = 3'b100;
`endif

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t              r_state;
    step_t              w_next;
    logic [IR_W-1:0]    r_ir;
    logic [2:0]         w_op;
    logic [2:0]         w_x;
    logic [2:0]         w_y;
    logic [7:0]         w_x_dec;
    logic [7:0]         w_y_dec;
    logic               w_is_arith;

`ifndef MVNZ_EN
    logic w_unused_gnz;
    assign w_unused_gnz = G_nz;
`endif

    assign w_op       = r_ir[8:6];
    assign w_x        = r_ir[5:3];
    assign w_y        = r_ir[2:0];
    assign w_x_dec    = 8'b1 << w_x;
    assign w_y_dec    = 8'b1 << w_y;
    assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);
    assign Tstep      = r_state;

    // Step register and instruction capture; IR only loads when Run is sampled in T0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == T0) && Run) begin
                r_ir <= DIN[IR_W-1:0];
            end
        end
    end

    // Next step and control strobes decoded from step, IR and Run.
    always_comb begin
        w_next = T0;
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;

        case (r_state)
            T0: begin
                IRin   = Run;
                w_next = Run ? T1 : T0;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        Rout = w_y_dec;
                        Rin  = w_x_dec;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = w_x_dec;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout   = w_x_dec;
                        Ain    = 1'b1;
                        w_next = T2;
                    end
`ifdef MVNZ_EN
                    OP_MVNZ: begin
                        if (G_nz) begin
                            Rout = w_y_dec;
                            Rin  = w_x_dec;
                        end
                        Done = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                if (w_is_arith) begin
                    Rout   = w_y_dec;
                    Gin    = 1'b1;
                    AddSub = (w_op == OP_SUB);
                    w_next = T3;
                end
            end
            T3: begin
                if (w_is_arith) begin
                    Gout = 1'b1;
                    Rin  = w_x_dec;
                    Done = 1'b1;
                end
            end
            default: w_next = T0;
        endcase

        // Hold every strobe low while reset is asserted, even if Run is high.
        if (!Resetn) begin
            IRin   = 1'b0;
            Rin    = '0;
            Rout   = '0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            Gout   = 1'b0;
            DINout = 1'b0;
            AddSub = 1'b0;
            Done   = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit: per-step strobe vectors and bus invariants.
module tb_proc_control_unit;

    localparam int unsigned N = 9;

    logic         Clock;
    logic         Resetn;
    logic         Run;
    logic [N-1:0] DIN;
    logic         G_nz;
    logic         IRin;
    logic [7:0]   Rin;
    logic [7:0]   Rout;
    logic         Ain;
    logic         Gin;
    logic         Gout;
    logic         DINout;
    logic         AddSub;
    logic         Done;
    logic [1:0]   Tstep;

    int n_tests = 0;
    int n_fail  = 0;

    logic [24:0] w_obs;
    assign w_obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep};

    proc_control_unit #(.N(N)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .G_nz   (G_nz),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Pack expected strobes in the same order as w_obs.
    function automatic logic [24:0] ev(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ain,
                                       input logic gin, input logic gout,
                                       input logic dinout, input logic addsub,
                                       input logic done, input logic [1:0] t);
        return {irin, rin, rout, ain, gin, gout, dinout, addsub, done, t};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] exp);
        #1;
        n_tests++;
        assert (w_obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag);
        n_tests++;
        assert (($countones({Rout, Gout, DINout}) <= 1) && $onehot0(Rin)) else begin
            n_fail++;
            $error("FAIL %s: observed rout=%b gout=%b dinout=%b rin=%b expected at most one driver, rin one-hot or zero",
                   tag, Rout, Gout, DINout, Rin);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 9'b001_010_000;
        G_nz   = 1'b0;
        tick();
        chk("reset_run_high", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        Resetn = 1'b1;
        Run    = 1'b0;
        tick();
        chk("idle_t0", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));

        // mvi R2, #imm
        Run = 1'b1;
        DIN = 9'b001_010_000;
        chk("mvi_t0", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        tick();
        Run = 1'b0;
        DIN = 9'h055;
        chk("mvi_t1", ev(0, 8'b0000_0100, 8'h00, 0, 0, 0, 1, 0, 1, 2'd1));
        tick();
        chk("mvi_back_t0", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));

        // mv R5, R3
        Run = 1'b1;
        DIN = 9'b000_101_011;
        tick();
        Run = 1'b0;
        chk("mv_t1", ev(0, 8'b0010_0000, 8'b0000_1000, 0, 0, 0, 0, 0, 1, 2'd1));
        tick();

        // sub R1, R2 with Run/DIN toggled mid-instruction (must be ignored)
        Run = 1'b1;
        DIN = 9'b011_001_010;
        tick();
        DIN = 9'b001_111_111;
        chk("sub_t1", ev(0, 8'h00, 8'b0000_0010, 1, 0, 0, 0, 0, 0, 2'd1));
        tick();
        chk("sub_t2", ev(0, 8'h00, 8'b0000_0100, 0, 1, 0, 0, 1, 0, 2'd2));
        tick();
        Run = 1'b0;
        chk("sub_t3", ev(0, 8'b0000_0010, 8'h00, 0, 0, 1, 0, 0, 1, 2'd3));
        tick();
        chk("sub_back_t0", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));

        // add R3, R3 (X == Y)
        Run = 1'b1;
        DIN = 9'b010_011_011;
        tick();
        Run = 1'b0;
        chk("addxx_t1", ev(0, 8'h00, 8'b0000_1000, 1, 0, 0, 0, 0, 0, 2'd1));
        tick();
        chk("addxx_t2", ev(0, 8'h00, 8'b0000_1000, 0, 1, 0, 0, 0, 0, 2'd2));
        tick();
        chk("addxx_t3", ev(0, 8'b0000_1000, 8'h00, 0, 0, 1, 0, 0, 1, 2'd3));
        tick();

        // NOP opcode 101
        Run = 1'b1;
        DIN = 9'b101_110_001;
        tick();
        Run = 1'b0;
        chk("nop_t1", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
        tick();

        // opcode 100: mvnz R0, R7
        for (int g = 0; g < 2; g++) begin
            G_nz = 1'(g);
            Run  = 1'b1;
            DIN  = 9'b100_000_111;
            tick();
            Run = 1'b0;
`ifdef MVNZ_EN
            if (g == 1)
                chk("mvnz_g1_t1", ev(0, 8'b0000_0001, 8'b1000_0000, 0, 0, 0, 0, 0, 1, 2'd1));
            else
                chk("mvnz_g0_t1", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
`else
            chk("op100_nop_t1", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
`endif
            tick();
        end
        G_nz = 1'b0;

        // Back-to-back with Run held: add R0,R1 then mvi R6
        Run = 1'b1;
        DIN = 9'b010_000_001;
        chk("b2b_c1", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        chk_bus("b2b_bus_c1");
        tick();
        DIN = 9'b001_110_000;
        chk("b2b_c2", ev(0, 8'h00, 8'b0000_0001, 1, 0, 0, 0, 0, 0, 2'd1));
        chk_bus("b2b_bus_c2");
        tick();
        chk("b2b_c3", ev(0, 8'h00, 8'b0000_0010, 0, 1, 0, 0, 0, 0, 2'd2));
        chk_bus("b2b_bus_c3");
        tick();
        chk("b2b_c4", ev(0, 8'b0000_0001, 8'h00, 0, 0, 1, 0, 0, 1, 2'd3));
        chk_bus("b2b_bus_c4");
        tick();
        chk("b2b_c5", ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        chk_bus("b2b_bus_c5");
        tick();
        Run = 1'b0;
        chk("b2b_c6", ev(0, 8'b0100_0000, 8'h00, 0, 0, 0, 1, 0, 1, 2'd1));
        chk_bus("b2b_bus_c6");
        tick();
        chk("b2b_c7", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));

        // Reset asserted mid-T2 of a sub, Run held high throughout
        Run = 1'b1;
        DIN = 9'b011_100_101;
        tick();
        tick();
        chk("rst_pre_t2", ev(0, 8'h00, 8'b0010_0000, 0, 1, 0, 0, 1, 0, 2'd2));
        Resetn = 1'b0;
        chk("rst_async", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        tick();
        chk("rst_held", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        Run    = 1'b0;
        Resetn = 1'b1;
        tick();
        chk("rst_release_idle", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
        tick();
        chk("rst_release_idle2", ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
Control FSM for the 9-bit bus-based didactic processor. It captures an instruction word from DIN into an internal IR, decodes opcode and register fields, and sequences the shared bus, register file enables, accumulator A, ALU result register G and adder/subtractor over steps T0..T3. It sits beside the regn instances and the add/sub unit, driving all their enables and the bus-select lines, and pulses Done at the end of each instruction.

Parameters:
N, 9, bus/DIN width; instruction is DIN[8:0]; N >= 9 required

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous reset, active low
Run  in  1  start request; sampled only in T0
DIN  in  N  external data/instruction input
G_nz  in  1  G register != 0 (used only with MVNZ_EN)
IRin  out  1  IR load strobe (internal IR also loads)
Rin  out  8  one-hot write enable for R0..R7
Rout  out  8  one-hot bus select for R0..R7
Ain  out  1  load A from bus
Gin  out  1  load G from add/sub result
Gout  out  1  bus select G
DINout  out  1  bus select DIN
AddSub  out  1  0 = add, 1 = subtract
Done  out  1  instruction complete, 1-cycle pulse
Tstep  out  2  current step: 0 = T0 .. 3 = T3 (debug/verification)

Behaviour:
- IR fields: I = IR[8:6] opcode, X = IR[5:3] dest/first operand, Y = IR[2:0] source. Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 mvnz (optional), others NOP.
- Reset (Resetn low, async): Tstep = T0, IR = 0; all outputs 0 while Resetn low, regardless of Run.
- Outputs are combinational from Tstep, the registered IR and Run; default 0 every cycle.
- T0: IRin = Run. Run = 1 -> IR <= DIN[8:0] at the edge, go to T1. Run = 0 -> stay in T0, IR holds.
- T1:
  - mv: Rout[Y], Rin[X], Done; -> T0.
  - mvi: DINout, Rin[X], Done; -> T0 (immediate taken from DIN during T1).
  - add/sub: Rout[X], Ain; -> T2.
  - NOP: Done only; -> T0.
- T2, add/sub: Rout[Y], Gin, AddSub = 1 for sub, 0 for add; -> T3.
- T3, add/sub: Gout, Rin[X], Done; -> T0.
- Latency from the Run-sampling edge: mv/mvi/NOP Done in the next cycle (2 cycles total including T0); add/sub Done in T3 (4 cycles total).
- Invariants:
  - Bus drivers: at most one of {Rout bits, Gout, DINout} is high per cycle.
  - Rin is zero or one-hot.
  - Done is high only in the last step of an instruction; the next step is always T0.
- X == Y (e.g. add R3,R3): legal; A captures R3 in T1, G = R3+R3, R3 written in T3.
- Run held high: back-to-back instructions; the IR reloads in the T0 following Done, with no idle cycle beyond T0.
- Run in T1..T3: ignored; no change to IR or sequence.
- Reset mid-instruction: immediate return to T0, no Done, no further Rin/Gin pulses.
- Unreachable encodings (T2/T3 for non-add/sub opcodes): outputs 0, next state T0.

Optional Feature:
MVNZ_EN.
- Defined: opcode 100 = mvnz. In T1 it asserts Rout[Y] and Rin[X] only if G_nz = 1, asserts Done unconditionally, then -> T0.
- Undefined: opcode 100 is a NOP (Done in T1, no enables) and G_nz is ignored.

Test Plan:
- Reset: Resetn low mid-T2 of a sub -> next sample shows Tstep = 0, all outputs 0; after release with Run = 0, stays T0 with IRin = 0.
- mvi: DIN = 9'b001_010_000, Run = 1 -> T1: DINout = 1, Rin = 8'b0000_0100, Done = 1; next cycle Tstep = 0.
- mv: DIN = 9'b000_101_011 -> T1: Rout = 8'b0000_1000, Rin = 8'b0010_0000, Done = 1.
- sub: DIN = 9'b011_001_010 -> T1: Rout[1], Ain. T2: Rout[2], Gin, AddSub = 1. T3: Gout, Rin[1], Done. No other bits high in any step.
- Back-to-back: Run held 1 with add then mvi -> Done in cycles 4 and 6; IRin high only in cycles 1 and 5; bus one-hot assertion holds throughout.
- mvnz (MVNZ_EN defined): DIN = 9'b100_000_111 with G_nz = 0 -> T1: Done = 1, Rin = 0. With G_nz = 1 -> Rout[7], Rin[0], Done. Without MVNZ_EN -> Done only.
